// File: rtl/renkon_pixel_feeder.sv
// renkon_pixel_feeder: raster-order pixel source feeding the line buffer, ending with one zero flush line
module renkon_pixel_feeder #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 8,
  parameter int AWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [LWIDTH-1:0]        img_size,
  input  logic [AWIDTH-1:0]        base_addr,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic                     mem_re,
  input  logic signed [DWIDTH-1:0] read_data,
  output logic                     buf_en,
  output logic signed [DWIDTH-1:0] buf_input,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_PREF = 2'd1, S_FEED = 2'd2, S_FLUSH = 2'd3} state_t;
  state_t            r_state, state_n;
  logic [LWIDTH-1:0] r_size, r_col, r_row, last_idx;
  logic [AWIDTH-1:0] r_addr;
  logic              r_done, col_end, row_end, start, zero_req, last_pix;
  assign last_idx  = r_size - LWIDTH'(1);
  assign col_end   = r_col == last_idx;
  assign row_end   = r_row == last_idx;
  assign last_pix  = col_end && row_end;
  assign start     = r_state == S_WAIT && req && img_size != '0;
  assign zero_req  = r_state == S_WAIT && req && img_size == '0;
  assign mem_addr  = r_addr;
  assign mem_re    = r_state == S_PREF || (r_state == S_FEED && !last_pix);
  assign buf_en    = r_state == S_FEED && r_row == '0 && r_col == '0;
  assign buf_input = r_state == S_FEED ? read_data : '0;
  assign busy      = r_state != S_WAIT;
  assign done      = r_done;
  // state register
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) r_state <= S_WAIT;
    else       r_state <= state_n;
  // next-state: prefetch one word, stream N*N pixels, then N flush cycles
  always_comb begin
    state_n = r_state;
    unique case (r_state)
      S_WAIT:  state_n = start ? S_PREF : S_WAIT;
      S_PREF:  state_n = S_FEED;
      S_FEED:  state_n = last_pix ? S_FLUSH : S_FEED;
      S_FLUSH: state_n = col_end ? S_WAIT : S_FLUSH;
      default: state_n = S_WAIT;
    endcase
  end
  // job registers, read address and raster counters
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      r_size <= '0;
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= zero_req || (r_state == S_FLUSH && col_end);
      if (start) begin
        r_size <= img_size;
        r_addr <= base_addr;
        r_col  <= '0;
        r_row  <= '0;
      end
      if (mem_re) r_addr <= r_addr + AWIDTH'(1);
      if (r_state == S_FEED) begin
        r_col <= col_end ? '0 : r_col + LWIDTH'(1);
        if (col_end) r_row <= row_end ? '0 : r_row + LWIDTH'(1);
      end
      if (r_state == S_FLUSH) r_col <= col_end ? '0 : r_col + LWIDTH'(1);
    end
endmodule

// File: tb/tb_renkon_pixel_feeder.sv
// tb_renkon_pixel_feeder: job table plus random jobs checked cycle-by-cycle against a timeline model
module tb_renkon_pixel_feeder;
  localparam int DW = 16, LW = 8, AW = 16;
  logic clk = 1'b0, xrst = 1'b0, req = 1'b0;
  logic [LW-1:0] img_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_addr;
  logic mem_re, buf_en, busy, done;
  logic signed [DW-1:0] read_data = '0;
  logic signed [DW-1:0] buf_input;
  int n_cmp = 0, n_bad = 0;
  bit hashed = 1'b0;

  always #5 clk = ~clk;

  renkon_pixel_feeder #(.DWIDTH(DW), .LWIDTH(LW), .AWIDTH(AW)) dut (
    .clk(clk), .xrst(xrst), .req(req), .img_size(img_size), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_re(mem_re), .read_data(read_data), .buf_en(buf_en),
    .buf_input(buf_input), .busy(busy), .done(done)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = a * 16'h9E37;
    return hashed ? DW'(h ^ 16'hA5C3) : DW'(a & 16'h00FF);
  endfunction

  // one-cycle-latency memory
  always @(posedge clk) if (mem_re) read_data <= mem_val(mem_addr);

  typedef struct packed {
    logic busy, en, re, dn;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } obs_t;

  function automatic obs_t mk(bit b, bit e, bit r, bit d, logic [AW-1:0] a, logic [DW-1:0] x);
    obs_t o;
    o.busy = b; o.en = e; o.re = r; o.dn = d; o.addr = a; o.data = x;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(busy, buf_en, mem_re, done, mem_re ? mem_addr : '0, buf_input);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got busy=%b en=%b re=%b done=%b addr=%h data=%h, want busy=%b en=%b re=%b done=%b addr=%h data=%h",
               name, got.busy, got.en, got.re, got.dn, got.addr, got.data,
               want.busy, want.en, want.re, want.dn, want.addr, want.data);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Expected timeline from the job rules: prefetch, N*N pixels, N zeros, done.
  task automatic run_job(input int n, input int base, input int ign_at, output int done_at, output int reads);
    obs_t q[$];
    obs_t o;
    int np;
    np = n * n;
    if (n == 0) q.push_back(mk(0, 0, 0, 1, '0, '0));
    else begin
      q.push_back(mk(1, 0, 1, 0, AW'(base), '0));
      for (int k = 0; k < np; k++)
        q.push_back(mk(1, k == 0, k < np - 1, 0, k < np - 1 ? AW'(base + k + 1) : '0, mem_val(AW'(base + k))));
      for (int f = 0; f < n; f++) q.push_back(mk(1, 0, 0, 0, '0, '0));
      q.push_back(mk(0, 0, 0, 1, '0, '0));
    end
    img_size = LW'(n);
    base_addr = AW'(base);
    req = 1'b1;
    done_at = -1;
    reads = 0;
    for (int c = 1; c <= q.size(); c++) begin
      @(posedge clk);
      #1;
      o = observe();
      check($sformatf("job n=%0d base=%h cyc=T+%0d", n, base, c), o, q[c-1]);
      if (o.dn && done_at < 0) done_at = c;
      reads += int'(o.re);
      req = (c == ign_at);
      if (c == ign_at) begin
        img_size = 8'd7;
        base_addr = 16'h0055;
      end
    end
    req = 1'b0;
  endtask

  typedef struct {
    int n;
    int base;
    bit hsh;
    int ign_at;
    int done_at;
    int reads;
  } job_t;

  job_t jobs[7];
  obs_t idle;
  int d_at, rd, rn, rb, ri;

  initial begin
    jobs = '{
      '{4, 'h0100, 1'b0, -1, 22, 16},
      '{4, 'h0100, 1'b0,  5, 22, 16},
      '{2, 'hFFFE, 1'b0, -1,  8,  4},
      '{0, 'h1234, 1'b0, -1,  1,  0},
      '{1, 'h0040, 1'b1, -1,  4,  1},
      '{5, 'h2000, 1'b1, -1, 32, 25},
      '{3, 'hFFFA, 1'b1,  3, 14,  9}
    };
    idle = mk(0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", observe(), idle);
    chk_int("reset mem_addr", int'(mem_addr), 0);
    xrst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      hashed = jobs[i].hsh;
      run_job(jobs[i].n, jobs[i].base, jobs[i].ign_at, d_at, rd);
      chk_int($sformatf("table %0d done_at", i), d_at, jobs[i].done_at);
      chk_int($sformatf("table %0d reads", i), rd, jobs[i].reads);
    end
    hashed = 1'b0;
    img_size = 8'd4;
    base_addr = 16'h0100;
    req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      req = 1'b0;
    end
    xrst = 1'b0;
    #1;
    check("midrst async", observe(), idle);
    chk_int("midrst mem_addr", int'(mem_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst held", observe(), idle);
    xrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-rst idle %0d", c), observe(), idle);
    end
    run_job(3, 'h0300, -1, d_at, rd);
    chk_int("after rst done_at", d_at, 14);
    chk_int("after rst reads", rd, 9);
    for (int r = 0; r < 20; r++) begin
      hashed = 1'b1;
      rn = int'($urandom_range(1, 6));
      rb = int'($urandom_range(0, 65535));
      ri = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, rn * rn + 1)) : -1;
      run_job(rn, rb, ri, d_at, rd);
      chk_int($sformatf("rand %0d done_at", r), d_at, 2 + rn * rn + rn);
      chk_int($sformatf("rand %0d reads", r), rd, rn * rn);
    end
    @(posedge clk);
    #1;
    check("final idle", observe(), idle);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
